// File: rtl/fp_round_pkg.sv
// Shared types and constants for the linear-to-floating-point encoder.
// Holds the rounding-mode codes, the FSM states and the input-width helper.
package fp_round_pkg;

  localparam logic [1:0] RM_TRUNC   = 2'b00;
  localparam logic [1:0] RM_HALF_UP = 2'b01;
  localparam logic [1:0] RM_RNE     = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND,
    ST_HOLD
  } state_t;

  function automatic int calc_in_w(input int exp_w, input int sig_w);
    return sig_w + (1 << exp_w);
  endfunction

endpackage

// File: rtl/fp_round_stage.sv
// Rounds a normalised (e, f, g, s) tuple and handles significand carry-out and exponent saturation.
// Purely combinational (0 cycles); it has no flow control of its own.
module fp_round_stage
  import fp_round_pkg::*;
#(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input  logic [EXP_W-1:0] i_e,
  input  logic [SIG_W-1:0] i_f,
  input  logic             i_g,
  input  logic             i_s,
  input  logic [1:0]       i_mode,
  output logic [EXP_W-1:0] o_e,
  output logic [SIG_W-1:0] o_f,
  output logic             o_ovf,
  output logic             o_inexact
);

  logic w_inc;

  always_comb begin
    case (i_mode)
      RM_TRUNC: w_inc = 1'b0;
      RM_RNE:   w_inc = i_g & (i_s | i_f[0]);
      default:  w_inc = i_g;
    endcase
  end

  always_comb begin
    o_e       = i_e;
    o_f       = i_f;
    o_ovf     = 1'b0;
    o_inexact = i_g | i_s;
    if (w_inc) begin
      if (&i_f) begin
        // Carry out of the significand: renormalise, or saturate at the top exponent.
        if (i_e != {EXP_W{1'b1}}) begin
          o_e = i_e + EXP_W'(1);
          o_f = {1'b1, {(SIG_W-1){1'b0}}};
        end else begin
          o_ovf = 1'b1;
        end
      end else begin
        o_f = i_f + SIG_W'(1);
      end
    end
  end

endmodule

// File: rtl/fp_round_encoder.sv
// Two's-complement sample to sign/exponent/significand encoder with selectable rounding.
// Latency k+2 cycles (k = normalising shifts); holds the result until out_ready, accepts one sample at a time.
module fp_round_encoder
  import fp_round_pkg::*;
#(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  localparam int IN_W = calc_in_w(EXP_W, SIG_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_ovf,
  output logic             out_inexact
);

  localparam int MAG_W = IN_W - 1;
  localparam logic [EXP_W-1:0] MAXE = '1;

  state_t           r_state;
  logic             r_sign;
  logic [MAG_W-1:0] r_mag;
  logic [1:0]       r_mode;
  logic [EXP_W-1:0] r_e;
  logic             r_clamp;
  logic             r_out_valid;
  logic             r_out_sign;
  logic [EXP_W-1:0] r_out_exp;
  logic [SIG_W-1:0] r_out_sig;
  logic             r_out_ovf;
  logic             r_out_inexact;

  logic             w_min;
  logic [MAG_W-1:0] w_mag;
  logic [SIG_W-1:0] w_f;
  logic             w_g;
  logic             w_s;
  logic [EXP_W-1:0] w_new_e;
  logic [SIG_W-1:0] w_new_f;
  logic             w_ovf;
  logic             w_inexact;

  // The most negative input has no positive counterpart in MAG_W bits, so it clamps.
  assign w_min = in_data[IN_W-1] & ~(|in_data[MAG_W-1:0]);
  assign w_mag = w_min ? {MAG_W{1'b1}} :
                 in_data[IN_W-1] ? (~in_data[MAG_W-1:0] + MAG_W'(1)) : in_data[MAG_W-1:0];

  assign w_f = r_mag[MAG_W-1 -: SIG_W];
  assign w_g = r_mag[MAG_W-1-SIG_W];
  assign w_s = |r_mag[MAG_W-2-SIG_W:0];

  fp_round_stage #(
    .EXP_W(EXP_W),
    .SIG_W(SIG_W)
  ) u_round (
    .i_e      (r_e),
    .i_f      (w_f),
    .i_g      (w_g),
    .i_s      (w_s),
    .i_mode   (r_mode),
    .o_e      (w_new_e),
    .o_f      (w_new_f),
    .o_ovf    (w_ovf),
    .o_inexact(w_inexact)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_sign        <= 1'b0;
      r_mag         <= '0;
      r_mode        <= RM_TRUNC;
      r_e           <= '0;
      r_clamp       <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_sign    <= 1'b0;
      r_out_exp     <= '0;
      r_out_sig     <= '0;
      r_out_ovf     <= 1'b0;
      r_out_inexact <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign  <= in_data[IN_W-1];
            r_mag   <= w_mag;
            r_mode  <= in_mode;
            r_e     <= MAXE;
            r_clamp <= w_min;
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (r_e == '0 || r_mag[MAG_W-1]) begin
            r_state <= ST_ROUND;
          end else begin
            r_mag <= {r_mag[MAG_W-2:0], 1'b0};
            r_e   <= r_e - EXP_W'(1);
          end
        end
        ST_ROUND: begin
          r_out_sign    <= r_sign;
          r_out_exp     <= w_new_e;
          r_out_sig     <= w_new_f;
          r_out_ovf     <= w_ovf | r_clamp;
          r_out_inexact <= w_inexact;
          r_out_valid   <= 1'b1;
          r_state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = r_out_valid;
  assign out_sign    = r_out_sign;
  assign out_exp     = r_out_exp;
  assign out_sig     = r_out_sig;
  assign out_ovf     = r_out_ovf;
  assign out_inexact = r_out_inexact;

endmodule

// File: tb/tb_fp_round_encoder.sv
// Directed-vector bench for fp_round_encoder at default parameters (EXP_W=3, SIG_W=4).
module tb_fp_round_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [2:0]  out_exp;
  logic [3:0]  out_sig;
  logic        out_ovf;
  logic        out_inexact;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_round_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_sig    (out_sig),
    .out_ovf    (out_ovf),
    .out_inexact(out_inexact)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one sample, measures edges to out_valid, checks the result, then handshakes it out.
  task automatic run_vec(input string tag, input logic [11:0] data, input logic [1:0] mode,
                         input int exp_lat, input logic e_sign, input logic [2:0] e_exp,
                         input logic [3:0] e_sig, input logic e_ovf, input logic e_inex);
    int lat = 0;
    bit seen = 0;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~data;
    in_mode  = ~mode;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) seen = 1;
    end
    chk({tag, ".lat"},  32'(lat), 32'(exp_lat));
    chk({tag, ".sign"}, 32'(out_sign), 32'(e_sign));
    chk({tag, ".exp"},  32'(out_exp), 32'(e_exp));
    chk({tag, ".sig"},  32'(out_sig), 32'(e_sig));
    chk({tag, ".ovf"},  32'(out_ovf), 32'(e_ovf));
    chk({tag, ".inex"}, 32'(out_inexact), 32'(e_inex));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".vld_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit any_vld;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.data", {25'd0, out_sign, out_exp, out_sig, out_ovf, out_inexact}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //      tag        data     mode   lat sgn exp  sig     ovf  inex
    run_vec("zero",    12'h000, 2'b01, 9, 0, 3'd0, 4'b0000, 0, 0);
    run_vec("125hu",   12'h07D, 2'b01, 6, 0, 3'd4, 4'b1000, 0, 1);
    run_vec("125tr",   12'h07D, 2'b00, 6, 0, 3'd3, 4'b1111, 0, 1);
    run_vec("21rne",   12'h015, 2'b10, 8, 0, 3'd1, 4'b1010, 0, 1);
    run_vec("21hu",    12'h015, 2'b01, 8, 0, 3'd1, 4'b1011, 0, 1);
    run_vec("21m11",   12'h015, 2'b11, 8, 0, 3'd1, 4'b1011, 0, 1);
    run_vec("23rne",   12'h017, 2'b10, 8, 0, 3'd1, 4'b1100, 0, 1);
    run_vec("64exact", 12'h040, 2'b01, 6, 0, 3'd3, 4'b1000, 0, 0);
    run_vec("denorm5", 12'h005, 2'b01, 9, 0, 3'd0, 4'b0101, 0, 0);
    run_vec("neg1",    12'hFFF, 2'b01, 9, 1, 3'd0, 4'b0001, 0, 0);
    run_vec("max",     12'h7FF, 2'b01, 2, 0, 3'd7, 4'b1111, 1, 1);
    run_vec("minhu",   12'h800, 2'b01, 2, 1, 3'd7, 4'b1111, 1, 1);
    run_vec("mintr",   12'h800, 2'b00, 2, 1, 3'd7, 4'b1111, 1, 1);

    // Backpressure: result held for 5 cycles while a second sample is offered.
    in_valid = 1'b1;
    in_data  = 12'hF83;
    in_mode  = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    any_vld  = 0;
    for (int i = 0; i < 20 && !any_vld; i++) begin
      @(posedge clk); #1;
      if (out_valid) any_vld = 1;
    end
    chk("hold.seen", 32'(any_vld), 32'd1);
    in_valid = 1'b1;
    in_data  = 12'h07D;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold.vld", 32'(out_valid), 32'd1);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      chk("hold.res", {24'd0, out_sign, out_exp, out_sig}, {24'd0, 1'b1, 3'd4, 4'b1000});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold.vld_drop", 32'(out_valid), 32'd0);
    chk("hold.in_ready_after", 32'(in_ready), 32'd1);
    chk("hold.kept", {24'd0, out_sign, out_exp, out_sig}, {24'd0, 1'b1, 3'd4, 4'b1000});
    any_vld = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) any_vld = 1;
    end
    chk("hold.no_second", 32'(any_vld), 32'd0);

    // Reset in the middle of normalisation discards the conversion.
    in_valid = 1'b1;
    in_data  = 12'h000;
    in_mode  = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.sig_clr", 32'(out_sig), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    any_vld = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) any_vld = 1;
    end
    chk("midrst.no_out", 32'(any_vld), 32'd0);
    run_vec("post_rst", 12'h07D, 2'b01, 6, 0, 3'd4, 4'b1000, 0, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_round_encoder.md
Name: fp_round_encoder

Overview:
- Sequential, parametrised linear-to-floating-point encoder with a selectable rounding mode.
- Converts a two's-complement sample into sign / exponent / significand format, value = sig * 2^exp.
- Normalises with an iterative one-bit-per-cycle shifter, then applies a rounding stage. That stage handles significand overflow and exponent saturation explicitly, with no latches.
- Sits between the sample source and the display/output logic, using valid/ready handshakes on both sides.

Parameters:
- EXP_W, 3: exponent width; MAXE = 2^EXP_W - 1.
- SIG_W, 4: significand width.
- Derived localparam IN_W = SIG_W + 2^EXP_W: input width (12 at defaults). MAG_W = IN_W - 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  IN_W  two's-complement sample.
- in_mode  in  2  rounding mode: 00 truncate, 01 round-half-up, 10 round-nearest-even, 11 treated as 01.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sign  out  1  sign bit.
- out_exp  out  EXP_W  exponent.
- out_sig  out  SIG_W  significand.
- out_ovf  out  1  result saturated.
- out_inexact  out  1  nonzero bits were discarded.

Behaviour:
- Reset (async, any state):
  - state goes to IDLE; internal registers clear.
  - in_ready = 1; out_valid = 0; all data outputs and flags = 0.
  - An in-flight conversion is discarded without output.
- States: IDLE, NORM, ROUND, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture the following and go to NORM:
    - sign = in_data[IN_W-1].
    - mag = |in_data| (MAG_W bits). The most negative input clamps to 2^MAG_W - 1 and sets a latched ovf flag.
    - mode = in_mode.
    - e = MAXE.
  - in_ready = 0 in every other state. in_mode and in_data are ignored after capture.
- NORM, one decision per cycle:
  - If e == 0 or mag[MAG_W-1] == 1, go to ROUND.
  - Otherwise mag <<= 1 (shift in 0) and e -= 1.
  - k = number of shifts, 0..MAXE.
- ROUND, single cycle:
  - f = mag[MAG_W-1 -: SIG_W]; g = the next bit; s = OR of the remaining bits; lsb = f[0].
  - Increment condition: mode 00 never; 01/11 when g; 10 when g & (s | lsb).
  - inexact = g | s.
  - If the increment is taken and f is all ones:
    - e < MAXE: e += 1, f = 1000..0 (MSB set).
    - e == MAXE: f stays all ones, e = MAXE, ovf = 1.
  - Otherwise f += increment.
  - Register all outputs, set out_valid = 1, go to HOLD.
- HOLD:
  - Outputs stable while out_valid && !out_ready.
  - On out_ready: out_valid = 0, go to IDLE. Data outputs keep their last values.
- Latency: out_valid rises k+2 clock edges after the accepting edge. Range is 2 to MAXE+2 (2 to 9 at defaults).
- Throughput: the next accept happens no earlier than the cycle after the out_ready handshake.
- Denormal range: when e reaches 0, g and s are 0 by construction, so no rounding occurs and the result is exact.

Decomposition:
- Package fp_round_pkg:
  - rounding-mode constants RM_TRUNC = 2'b00, RM_HALF_UP = 2'b01, RM_RNE = 2'b10.
  - state enum.
  - helper for deriving IN_W from EXP_W and SIG_W.
- Sub-module fp_round_stage: combinational rounding of (e, f, g, s, mode), producing (new_e, new_f, ovf, inexact). It is instantiated in the ROUND state and is unit-testable on its own.

Test Plan (defaults EXP_W=3, SIG_W=4, IN_W=12):
- in_data=0x000, mode 01 -> k=7, out_valid 9 edges after accept; sign 0, exp 0, sig 0000, ovf 0, inexact 0.
- in_data=0x07D (125):
  - mode 01 -> exp 4, sig 1000 (128), inexact 1, latency 6.
  - mode 00 -> exp 3, sig 1111 (120), inexact 1.
- in_data=0x015 (21):
  - mode 10 (tie, even) -> exp 1, sig 1010 (20).
  - mode 01 -> exp 1, sig 1011 (22); both inexact 1.
- in_data=0x7FF, mode 01 -> latency 2; exp 7, sig 1111, ovf 1. in_data=0x800 -> sign 1, exp 7, sig 1111, ovf 1.
- in_data=0xF83 (-125), mode 01, out_ready held low 5 cycles -> outputs stable; in_ready 0 throughout; a second in_valid is ignored. On out_ready: sign 1, exp 4, sig 1000, then in_ready 1 next cycle.
- rst asserted mid-NORM -> out_valid stays 0, in_ready 1 immediately. Next sample 0x07D converts correctly.
